// File: rtl/phase_scheduler_if.sv
// ---------------------------------------------------------------------------
// phase_scheduler_if
//   Bundles the note-event handshake, the tuning-word LUT hookup and the
//   per-voice phase output stream of phase_scheduler.
//
//   Parameters
//     VOICES   number of voice slots (2..16)
//     PHASE_W  phase accumulator / tuning word width
//
//   Signals (direction as seen from the scheduler, i.e. the slave modport)
//     i_sample_tick  in   one-cycle pulse that starts a phase-update sweep
//     i_note_valid   in   note event request
//     o_note_ready   out  note event accept (transfer on valid & ready)
//     i_note_on      in   1 = note-on, 0 = note-off
//     i_midi         in   MIDI note number of the event
//     o_tw_midi      out  note of the voice being swept, to the tuning LUT
//     i_tw           in   tuning word returned combinationally for o_tw_midi
//     o_phase_valid  out  o_phase / o_voice_idx / o_voice_midi are valid
//     o_voice_idx    out  voice index of o_phase
//     o_phase        out  updated phase of the voice
//     o_voice_midi   out  note of the voice, 0 = free
//     o_frame_done   out  pulse on the last voice of a sweep
//     o_overrun      out  pulse when a tick arrives during a sweep
//     o_drop         out  pulse when a note-on is discarded
//
//   Modports: master (event source / LUT / phase consumer), slave (scheduler)
// ---------------------------------------------------------------------------
interface phase_scheduler_if #(
    parameter int unsigned VOICES  = 4,
    parameter int unsigned PHASE_W = 16
);
    localparam int unsigned IDX_W = $clog2(VOICES);

    logic               i_sample_tick;
    logic               i_note_valid;
    logic               o_note_ready;
    logic               i_note_on;
    logic [6:0]         i_midi;
    logic [6:0]         o_tw_midi;
    logic [PHASE_W-1:0] i_tw;
    logic               o_phase_valid;
    logic [IDX_W-1:0]   o_voice_idx;
    logic [PHASE_W-1:0] o_phase;
    logic [6:0]         o_voice_midi;
    logic               o_frame_done;
    logic               o_overrun;
    logic               o_drop;

    modport master (
        output i_sample_tick, i_note_valid, i_note_on, i_midi, i_tw,
        input  o_note_ready, o_tw_midi, o_phase_valid, o_voice_idx, o_phase,
               o_voice_midi, o_frame_done, o_overrun, o_drop
    );

    modport slave (
        input  i_sample_tick, i_note_valid, i_note_on, i_midi, i_tw,
        output o_note_ready, o_tw_midi, o_phase_valid, o_voice_idx, o_phase,
               o_voice_midi, o_frame_done, o_overrun, o_drop
    );
endinterface

// File: rtl/phase_scheduler.sv
// ---------------------------------------------------------------------------
// phase_scheduler
//   Polyphonic phase accumulator scheduler. Holds VOICES voice slots, each
//   with a MIDI note (0 = free) and a PHASE_W-bit phase. A sample tick starts
//   a sweep that visits one voice per cycle, looks up its tuning word through
//   a shared external LUT and streams the updated phase out. Note events are
//   accepted only between sweeps.
//
//   Ports
//     clk    system clock, rising edge
//     reset  asynchronous, active-high reset
//     bus    phase_scheduler_if.slave (handshake, LUT and phase stream)
//
//   Timing (tick sampled at edge T)
//     voice k result registered at edge T+1+k, o_frame_done at edge T+VOICES,
//     o_note_ready low from edge T until edge T+VOICES.
//
//   Configuration
//     VOICE_STEAL_EN  when defined, a note-on with all voices busy replaces
//                     the voice at a round-robin steal pointer; otherwise the
//                     note-on is dropped and o_drop pulses.
// ---------------------------------------------------------------------------
module phase_scheduler #(
    parameter int unsigned VOICES  = 4,
    parameter int unsigned PHASE_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    phase_scheduler_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(VOICES);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(VOICES - 1);

    typedef enum logic [0:0] {StIdle, StSweep} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;

    // Voice table
    logic [6:0]         midi_q  [VOICES];
    logic [6:0]         midi_d  [VOICES];
    logic [PHASE_W-1:0] phase_q [VOICES];
    logic [PHASE_W-1:0] phase_d [VOICES];

`ifdef VOICE_STEAL_EN
    logic [IDX_W-1:0]   steal_q, steal_d;
`endif

    // Registered outputs
    logic               pvalid_q, pvalid_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [PHASE_W-1:0] pout_q, pout_d;
    logic [6:0]         vmidi_q, vmidi_d;
    logic               done_q, done_d;
    logic               overrun_q, overrun_d;
    logic               drop_q, drop_d;

    // Event decode
    logic               accept;
    logic               match_found, free_found;
    logic [IDX_W-1:0]   match_idx, free_idx;

    // Voice currently visited by the sweep
    logic [6:0]         cur_midi;
    logic [PHASE_W-1:0] cur_phase;

    assign accept   = bus.i_note_valid && (state_q == StIdle);
    assign cur_midi = midi_q[cnt_q];
    // A free voice never accumulates; its phase stays pinned at 0.
    assign cur_phase = (cur_midi != 7'd0) ? (phase_q[cnt_q] + bus.i_tw) : '0;

    // Search for an active voice playing i_midi and for the lowest free slot.
    // Scanning downward lets the lowest index win.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = int'(VOICES) - 1; i >= 0; i--) begin
            if (midi_q[i] != 7'd0 && midi_q[i] == bus.i_midi) begin
                match_found = 1'b1;
                match_idx   = IDX_W'(i);
            end
            if (midi_q[i] == 7'd0) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Voice table next state. Events land only in IDLE and phase updates only
    // in SWEEP, so the two never write the table in the same cycle. An event
    // accepted together with a tick is therefore visible to the whole sweep.
    always_comb begin
        midi_d  = midi_q;
        phase_d = phase_q;
        drop_d  = 1'b0;
`ifdef VOICE_STEAL_EN
        steal_d = steal_q;
`endif
        if (accept) begin
            if (bus.i_note_on) begin
                if (bus.i_midi != 7'd0) begin
                    if (match_found) begin
                        phase_d[match_idx] = '0;             // retrigger
                    end else if (free_found) begin
                        midi_d[free_idx]  = bus.i_midi;
                        phase_d[free_idx] = '0;
                    end else begin
`ifdef VOICE_STEAL_EN
                        midi_d[steal_q]  = bus.i_midi;
                        phase_d[steal_q] = '0;
                        steal_d = (steal_q == LastIdx) ? '0 : steal_q + IDX_W'(1);
`else
                        drop_d = 1'b1;
`endif
                    end
                end
            end else if (match_found) begin
                midi_d[match_idx]  = '0;
                phase_d[match_idx] = '0;
            end
        end
        if (state_q == StSweep) begin
            phase_d[cnt_q] = cur_phase;
        end
    end

    // Sweep FSM and registered output stream
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pvalid_d  = 1'b0;
        idx_d     = '0;
        pout_d    = '0;
        vmidi_d   = '0;
        done_d    = 1'b0;
        overrun_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.i_sample_tick) begin
                    state_d = StSweep;
                    cnt_d   = '0;
                end
            end
            StSweep: begin
                overrun_d = bus.i_sample_tick;
                pvalid_d  = 1'b1;
                idx_d     = cnt_q;
                pout_d    = cur_phase;
                vmidi_d   = cur_midi;
                if (cnt_q == LastIdx) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            for (int i = 0; i < int'(VOICES); i++) begin
                midi_q[i]  <= '0;
                phase_q[i] <= '0;
            end
`ifdef VOICE_STEAL_EN
            steal_q   <= '0;
`endif
            pvalid_q  <= 1'b0;
            idx_q     <= '0;
            pout_q    <= '0;
            vmidi_q   <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            midi_q    <= midi_d;
            phase_q   <= phase_d;
`ifdef VOICE_STEAL_EN
            steal_q   <= steal_d;
`endif
            pvalid_q  <= pvalid_d;
            idx_q     <= idx_d;
            pout_q    <= pout_d;
            vmidi_q   <= vmidi_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.o_note_ready  = (state_q == StIdle);
    assign bus.o_tw_midi     = (state_q == StSweep) ? cur_midi : 7'd0;
    assign bus.o_phase_valid = pvalid_q;
    assign bus.o_voice_idx   = idx_q;
    assign bus.o_phase       = pout_q;
    assign bus.o_voice_midi  = vmidi_q;
    assign bus.o_frame_done  = done_q;
    assign bus.o_overrun     = overrun_q;
    assign bus.o_drop        = drop_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// ---------------------------------------------------------------------------
// tb_phase_scheduler
//   Directed bench for phase_scheduler (VOICES = 4, PHASE_W = 16). Expected
//   values are hand-computed; define VOICE_STEAL_EN to check the steal build.
// ---------------------------------------------------------------------------
module tb_phase_scheduler;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    phase_scheduler_if #(.VOICES(4), .PHASE_W(16)) bus ();

    phase_scheduler #(.VOICES(4), .PHASE_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic note(input logic on, input logic [6:0] midi);
        bus.i_note_valid = 1'b1;
        bus.i_note_on    = on;
        bus.i_midi       = midi;
        step();
        bus.i_note_valid = 1'b0;
    endtask

    // Pulses a tick (any note event already driven is sampled with it) and
    // checks the full sweep. ph/md hold voice 0 in the low bits.
    task automatic sweep(input string tag, input logic [63:0] ph, input logic [27:0] md);
        bus.i_sample_tick = 1'b1;
        step();
        bus.i_sample_tick = 1'b0;
        bus.i_note_valid  = 1'b0;
        chk({tag, ".ready_T"}, {31'd0, bus.o_note_ready}, 32'd0);
        chk({tag, ".twmidi_T"}, {25'd0, bus.o_tw_midi}, {25'd0, md[6:0]});
        chk({tag, ".valid_T"}, {31'd0, bus.o_phase_valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("%s.valid%0d", tag, k), {31'd0, bus.o_phase_valid}, 32'd1);
            chk($sformatf("%s.idx%0d", tag, k), {30'd0, bus.o_voice_idx}, k);
            chk($sformatf("%s.phase%0d", tag, k), {16'd0, bus.o_phase}, {16'd0, ph[k*16 +: 16]});
            chk($sformatf("%s.vmidi%0d", tag, k), {25'd0, bus.o_voice_midi},
                {25'd0, md[k*7 +: 7]});
            chk($sformatf("%s.done%0d", tag, k), {31'd0, bus.o_frame_done}, (k == 3) ? 1 : 0);
            chk($sformatf("%s.ready%0d", tag, k), {31'd0, bus.o_note_ready}, (k == 3) ? 1 : 0);
            if (k < 3) begin
                chk($sformatf("%s.twmidi%0d", tag, k + 1), {25'd0, bus.o_tw_midi},
                    {25'd0, md[(k+1)*7 +: 7]});
            end else begin
                chk({tag, ".twmidi_idle"}, {25'd0, bus.o_tw_midi}, 32'd0);
            end
        end
        step();
        chk({tag, ".valid_end"}, {31'd0, bus.o_phase_valid}, 32'd0);
        chk({tag, ".phase_end"}, {16'd0, bus.o_phase}, 32'd0);
        chk({tag, ".done_end"}, {31'd0, bus.o_frame_done}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".valid"}, {31'd0, bus.o_phase_valid}, 32'd0);
        chk({tag, ".phase"}, {16'd0, bus.o_phase}, 32'd0);
        chk({tag, ".idx"}, {30'd0, bus.o_voice_idx}, 32'd0);
        chk({tag, ".vmidi"}, {25'd0, bus.o_voice_midi}, 32'd0);
        chk({tag, ".done"}, {31'd0, bus.o_frame_done}, 32'd0);
        chk({tag, ".overrun"}, {31'd0, bus.o_overrun}, 32'd0);
        chk({tag, ".drop"}, {31'd0, bus.o_drop}, 32'd0);
        chk({tag, ".ready"}, {31'd0, bus.o_note_ready}, 32'd1);
        chk({tag, ".twmidi"}, {25'd0, bus.o_tw_midi}, 32'd0);
    endtask

    logic [6:0] v0_full;

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.i_sample_tick = 1'b0;
        bus.i_note_valid  = 1'b0;
        bus.i_note_on     = 1'b0;
        bus.i_midi        = 7'd0;
        bus.i_tw          = 16'd0;
`ifdef VOICE_STEAL_EN
        v0_full = 7'h4c;
`else
        v0_full = 7'h3c;
`endif

        // Reset state
        step();
        step();
        chk_reset_outputs("rst");
        reset = 1'b0;
        step();

        // Basic accumulate: 0x1d5f then 0x3abe
        chk("ready_idle", {31'd0, bus.o_note_ready}, 32'd1);
        note(1'b1, 7'h45);
        chk("drop_on45", {31'd0, bus.o_drop}, 32'd0);
        bus.i_tw = 16'h1d5f;
        sweep("sw1", {16'h0, 16'h0, 16'h0, 16'h1d5f}, {7'h0, 7'h0, 7'h0, 7'h45});
        sweep("sw2", {16'h0, 16'h0, 16'h0, 16'h3abe}, {7'h0, 7'h0, 7'h0, 7'h45});

        // Wrap-around: reach 0xf000, then add 0x2000
        bus.i_tw = 16'hb542;
        sweep("sw_f000", {16'h0, 16'h0, 16'h0, 16'hf000}, {7'h0, 7'h0, 7'h0, 7'h45});
        bus.i_tw = 16'h2000;
        sweep("sw_wrap", {16'h0, 16'h0, 16'h0, 16'h1000}, {7'h0, 7'h0, 7'h0, 7'h45});

        // Overrun: second tick two edges into the sweep
        bus.i_tw = 16'h0100;
        bus.i_sample_tick = 1'b1;
        step();                                   // edge T
        bus.i_sample_tick = 1'b0;
        step();                                   // T+1
        chk("ovr.phase0", {16'd0, bus.o_phase}, 32'h1100);
        chk("ovr.flag1", {31'd0, bus.o_overrun}, 32'd0);
        bus.i_sample_tick = 1'b1;
        step();                                   // T+2
        bus.i_sample_tick = 1'b0;
        chk("ovr.flag2", {31'd0, bus.o_overrun}, 32'd1);
        chk("ovr.idx2", {30'd0, bus.o_voice_idx}, 32'd1);
        step();                                   // T+3
        chk("ovr.flag3", {31'd0, bus.o_overrun}, 32'd0);
        chk("ovr.done3", {31'd0, bus.o_frame_done}, 32'd0);
        step();                                   // T+4
        chk("ovr.done4", {31'd0, bus.o_frame_done}, 32'd1);
        chk("ovr.idx4", {30'd0, bus.o_voice_idx}, 32'd3);
        step();                                   // T+5: no second sweep
        chk("ovr.valid5", {31'd0, bus.o_phase_valid}, 32'd0);
        chk("ovr.done5", {31'd0, bus.o_frame_done}, 32'd0);

        // Note-off, then note-on accepted together with a tick
        note(1'b0, 7'h45);
        bus.i_note_valid = 1'b1;
        bus.i_note_on    = 1'b1;
        bus.i_midi       = 7'h45;
        bus.i_tw         = 16'h1234;
        sweep("sw_same", {16'h0, 16'h0, 16'h0, 16'h1234}, {7'h0, 7'h0, 7'h0, 7'h45});

        // Retrigger: phase back to 0, no second voice allocated
        note(1'b1, 7'h45);
        bus.i_tw = 16'h0011;
        sweep("sw_retrig", {16'h0, 16'h0, 16'h0, 16'h0011}, {7'h0, 7'h0, 7'h0, 7'h45});

        // Fill all voices, then one more note-on
        note(1'b0, 7'h45);
        note(1'b1, 7'h3c);
        note(1'b1, 7'h40);
        note(1'b1, 7'h43);
        note(1'b1, 7'h48);
        chk("drop_fill", {31'd0, bus.o_drop}, 32'd0);
        note(1'b1, 7'h4c);
`ifdef VOICE_STEAL_EN
        chk("drop_full", {31'd0, bus.o_drop}, 32'd0);
`else
        chk("drop_full", {31'd0, bus.o_drop}, 32'd1);
`endif
        step();
        chk("drop_pulse_end", {31'd0, bus.o_drop}, 32'd0);
        bus.i_tw = 16'h0100;
        sweep("sw_full", {16'h0100, 16'h0100, 16'h0100, 16'h0100},
              {7'h48, 7'h43, 7'h40, v0_full});

        // Free voice 1 and reallocate it
        note(1'b0, 7'h40);
        note(1'b1, 7'h30);
        bus.i_tw = 16'h0200;
        sweep("sw_realloc", {16'h0300, 16'h0300, 16'h0200, 16'h0300},
              {7'h48, 7'h43, 7'h30, v0_full});

        // Note-on with midi 0 is ignored without a drop pulse
        note(1'b1, 7'h00);
        chk("drop_midi0", {31'd0, bus.o_drop}, 32'd0);

        // Reset in the middle of a sweep
        bus.i_tw = 16'h0700;
        bus.i_sample_tick = 1'b1;
        step();
        bus.i_sample_tick = 1'b0;
        step();
        chk("mid.valid_before", {31'd0, bus.o_phase_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk_reset_outputs("mid_async");
        step();
        step();
        chk_reset_outputs("mid_held");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("post.done%0d", i), {31'd0, bus.o_frame_done}, 32'd0);
            chk($sformatf("post.valid%0d", i), {31'd0, bus.o_phase_valid}, 32'd0);
        end

        // First tick after reset sweeps an all-free table
        bus.i_tw = 16'h5555;
        sweep("sw_post", 64'd0, 28'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
